uart_frame_tx: RTL and testbench

Framed UART transmitter for the beacon FPGA. It carries packed control words out to the SMPS Arduino (24-bit `{11'b0, state, val}`) and to the ESP32 (16-bit `{3'b0, state, val}`). Each word is serialised as 8N1 bytes: a header byte, the data bytes MSB-first, then a checksum byte. One instance is used per link; the two links differ only in `WORD_BYTES`.

---
 rtl/uart_frame_tx.sv | 146 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter: header byte, WORD_BYTES data bytes MSB-first, then a
// modulo-256 checksum byte. One instance per link; links differ only in WORD_BYTES.
module uart_frame_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          WORD_BYTES   = 3,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*WORD_BYTES-1:0] data_in,
    input  logic                    send,
    output logic                    busy,
    output logic                    done,
    output logic                    tx
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(WORD_BYTES + 2);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(WORD_BYTES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_nx;
    logic [BAUD_W-1:0]   baud_cnt, baud_nx;
    logic [2:0]          bit_idx, bit_nx;
    logic [IDX_W-1:0]    byte_idx, byte_nx;
    logic [DATA_W-1:0]   shift_buf, shift_nx;
    logic [7:0]          csum, csum_nx;
    logic                tx_nx, done_nx;
    logic [7:0]          cur_byte;
    logic                baud_end;

    function automatic logic [7:0] byte_sum(input logic [DATA_W-1:0] w);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < WORD_BYTES; i++) s = s + w[8*i +: 8];
        return s;
    endfunction

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign busy     = (state != IDLE);

    // The data byte in flight is always the top byte of the shift buffer.
    always_comb begin
        if (byte_idx == '0)
            cur_byte = HEADER;
        else if (byte_idx == LAST_BYTE)
            cur_byte = csum;
        else
            cur_byte = shift_buf[DATA_W-1 -: 8];
    end

    // tx_nx is the line level for the state being entered, so tx stays a clean flop.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        byte_nx  = byte_idx;
        shift_nx = shift_buf;
        csum_nx  = csum;
        tx_nx    = tx;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (send) begin
                    state_nx = START;
                    baud_nx  = '0;
                    bit_nx   = '0;
                    byte_nx  = '0;
                    shift_nx = data_in;
                    csum_nx  = byte_sum(data_in);
                    tx_nx    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nx = DATA;
                    baud_nx  = '0;
                    bit_nx   = '0;
                    tx_nx    = cur_byte[0];
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                        tx_nx  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_nx = '0;
                    if (byte_idx != LAST_BYTE) begin
                        state_nx = START;
                        byte_nx  = byte_idx + 1'b1;
                        tx_nx    = 1'b0;
                        if (byte_idx != '0) shift_nx = shift_buf << 8;
                    end else begin
                        state_nx = IDLE;
                        tx_nx    = 1'b1;
                        done_nx  = 1'b1;
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_buf <= '0;
            csum      <= '0;
            tx        <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_nx;
            bit_idx   <= bit_nx;
            byte_idx  <= byte_nx;
            shift_buf <= shift_nx;
            csum      <= csum_nx;
            tx        <= tx_nx;
            done      <= done_nx;
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: stimulus queues expected line bytes and busy
// windows; independent monitors decode the line and time busy/done.
module tb_uart_frame_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n, send3, send2, sel;
    logic [23:0] data3;
    logic [15:0] data2;
    logic        tx3, busy3, done3, tx2, busy2, done2;
    logic        tx_sel, busy_sel, done_sel;

    typedef struct { int len; bit done; } busy_exp_t;

    logic [7:0] exp_bytes[$];
    busy_exp_t  exp_busy[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(3), .HEADER(8'hA5)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_in(data3), .send(send3),
        .busy(busy3), .done(done3), .tx(tx3));

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(2), .HEADER(8'hA5)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data2), .send(send2),
        .busy(busy2), .done(done2), .tx(tx2));

    assign tx_sel   = sel ? tx2   : tx3;
    assign busy_sel = sel ? busy2 : busy3;
    assign done_sel = sel ? done2 : done3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes packed first-sent in the most significant position.
    task automatic exp_frame(input int n, input logic [47:0] bytes, input int len, input bit dn);
        busy_exp_t e;
        for (int i = 0; i < n; i++) exp_bytes.push_back(bytes[8*(n-1-i) +: 8]);
        e.len  = len;
        e.done = dn;
        exp_busy.push_back(e);
    endtask

    // Returns at the falling edge inside the first cycle after acceptance.
    task automatic send_word(input bit to2, input logic [23:0] w);
        @(negedge clk);
        if (to2) begin data2 = w[15:0]; send2 = 1'b1; end
        else     begin data3 = w;       send3 = 1'b1; end
        @(negedge clk);
        send2 = 1'b0;
        send3 = 1'b0;
        check("accept_start_tx", tx_sel, 1'b0);
        check("accept_busy", busy_sel, 1'b1);
    endtask

    // Line decoder: sample mid-bit, LSB first, check framing, compare against scoreboard.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_sel === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                check("start_bit", tx_sel, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_sel;
                end
                repeat (CPB) @(negedge clk);
                check("stop_bit", tx_sel, 1'b1);
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", b, $time);
                end else begin
                    check("line_byte", b, exp_bytes.pop_front());
                end
            end
        end
    end

    // Busy-window / done monitor.
    initial begin
        int        run;
        logic      pb, pd;
        busy_exp_t e;
        run = 0; pb = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_sel === 1'b1) begin
                run++;
            end else if (pb) begin
                if (exp_busy.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_busy: got %0d busy cycles, expected none", run);
                end else begin
                    e = exp_busy.pop_front();
                    check("busy_len", run, e.len);
                    check("done_at_end", done_sel, e.done);
                end
                run = 0;
            end
            if (done_sel === 1'b1) begin
                check("done_align", {pb, busy_sel}, 2'b10);
                check("done_one_cycle", pd, 1'b0);
            end
            pb = (busy_sel === 1'b1);
            pd = (done_sel === 1'b1);
        end
    end

    initial begin
        bit got;
        rst_n = 1'b0; send3 = 1'b0; send2 = 1'b0; sel = 1'b0;
        data3 = '0; data2 = '0;

        // 1: reset values, then quiet idle
        repeat (3) @(negedge clk);
        check("rst_tx", tx3, 1'b1);
        check("rst_busy", busy3, 1'b0);
        check("rst_done", done3, 1'b0);
        check("rst_tx_w2", tx2, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_line", {tx3, busy3, done3}, 3'b100);
        end

        // 2: basic frame, 200 busy cycles, done on cycle 201
        exp_frame(5, 48'h00_A5_12_34_56_9C, 200, 1'b1);
        send_word(1'b0, 24'h123456);
        repeat (230) @(negedge clk);

        // 3: checksum wrap; send and data changes mid-frame are ignored
        exp_frame(5, 48'h00_A5_FF_FF_FF_FD, 200, 1'b1);
        send_word(1'b0, 24'hFFFFFF);
        repeat (60) @(negedge clk);
        data3 = 24'h111111;
        send3 = 1'b1;
        repeat (20) @(negedge clk);
        send3 = 1'b0;
        repeat (150) @(negedge clk);

        // 4: send held high -> back-to-back frames with one idle cycle between
        exp_frame(5, 48'h00_A5_00_00_01_01, 200, 1'b1);
        exp_frame(5, 48'h00_A5_00_00_02_02, 200, 1'b1);
        @(negedge clk);
        data3 = 24'h000001;
        send3 = 1'b1;
        @(negedge clk);
        data3 = 24'h000002;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done3 === 1'b1) got = 1'b1;
        end
        check("b2b_done_seen", got, 1'b1);
        check("b2b_gap_tx", tx3, 1'b1);
        @(negedge clk);
        check("b2b_restart_tx", tx3, 1'b0);
        check("b2b_restart_busy", busy3, 1'b1);
        send3 = 1'b0;
        repeat (230) @(negedge clk);

        // 5: reset during bit 2 of byte 2. The decoder sees bits 0-1 of 0x34 then idle
        // high, so the truncated byte decodes as 0xFC; busy drops after 94 cycles, no done.
        exp_frame(3, 48'h00_00_00_A5_12_FC, 94, 1'b0);
        send_word(1'b0, 24'h123456);
        repeat (93) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_tx", tx3, 1'b1);
        check("midrst_busy", busy3, 1'b0);
        check("midrst_done", done3, 1'b0);
        repeat (40) @(negedge clk);
        exp_frame(5, 48'h00_A5_AB_CD_EF_67, 200, 1'b1);
        send_word(1'b0, 24'hABCDEF);
        repeat (230) @(negedge clk);

        // 6: two-byte link
        sel = 1'b1;
        exp_frame(4, 48'h00_00_A5_0A_3F_49, 160, 1'b1);
        send_word(1'b1, 24'h000A3F);
        repeat (190) @(negedge clk);

        check("bytes_outstanding", exp_bytes.size(), 0);
        check("busy_outstanding", exp_busy.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
